rr_arb_mux: RTL and testbench
=============================

// Module: rr_arb_mux
// PURPOSE
//  GN-channel arbitrated one-hot data mux with valid/ready handshake and a registered output stage.
//  Successor to the enable-select mux: grants are generated internally by a fixed-priority or
//  round-robin arbiter rather than supplied by the caller.
//  Optional packet lock holds the grant until the last beat of a packet.
//  Sits between several local producers and a single shared downstream consumer.
// PARAMETERS
//  GN    4  number of input channels (>=2)
//  GW    8  data width per channel
//  MODE  1  0 = fixed priority (channel 0 highest); 1 = round robin
//  LOCK  0  1 = grant held from first accepted beat until the beat with Da_Lst=1 is accepted
// PORTS
//  Clk     in   1      clock; all logic on rising edge
//  Rst     in   1      synchronous, active-high reset
//  Da_In   in   GN*GW  packed data; channel i = Da_In[GW*i +: GW]
//  Da_Vld  in   GN     per-channel valid
//  Da_Lst  in   GN     per-channel last-beat flag (ignored when LOCK=0)
//  Da_Rdy  out  GN     per-channel ready; at most one bit high in any cycle
//  Da_Ou   out  GW     registered selected data
//  Ou_Vld  out  1      Da_Ou valid
//  Ou_Lst  out  1      registered Da_Lst of the granted channel
//  Ou_Gnt  out  GN     registered one-hot channel that produced Da_Ou
//  Ou_Idx  out  CW     binary index of Ou_Gnt; CW = max(1,$clog2(GN))
//  Ou_Rdy  in   1      downstream ready
// BEHAVIOUR
//  - Reset: Da_Ou=0, Ou_Vld=0, Ou_Lst=0, Ou_Gnt=0, Ou_Idx=0, rr pointer=0, lock flag=0.
//    Da_Rdy is combinational and equals 0 during reset.
//  - Load enable: Ld = ~Ou_Vld | Ou_Rdy. Transfer on channel i when Da_Vld[i] & Da_Rdy[i].
//  - Da_Rdy[i] = Gnt[i] & Ld. Gnt is the combinational one-hot arbiter result. Gnt=0 when no Da_Vld.
//    No combinational path exists from Da_In to any output.
//  - Latency: 1 cycle. Transfer at edge N means Da_Ou/Ou_Vld reflect it after edge N.
//  - Throughput: 1 beat/cycle while Ou_Rdy=1.
//  - Output register, each edge:
//    - Ld & |Gnt: load Da_Ou, Ou_Lst, Ou_Gnt, Ou_Idx; set Ou_Vld=1.
//    - Ld & ~|Gnt: Ou_Vld<=0; data fields hold their previous value.
//    - ~Ld: all outputs hold stable (stall).
//  - Arbiter, MODE=1:
//    - Search starts at pointer P and wraps modulo GN.
//    - After a transfer on channel k: P <= (k+1) mod GN.
//    - P is unchanged when there is no transfer or a stall.
//    - Wrap: k=GN-1 gives P=0.
//  - Arbiter, MODE=0: lowest-index valid channel wins; P is unused.
//  - LOCK=1 uses a two-state FSM:
//    - IDLE: arbitrate normally. A transfer with Da_Lst=0 goes to HOLD and latches the channel.
//    - HOLD: Gnt is forced to the latched channel, whether or not it is valid. Other channels get
//      Da_Rdy=0. A transfer with Da_Lst=1 returns to IDLE and updates P as above.
//    - A single-beat packet (Da_Lst=1 on the first beat) stays in IDLE.
//    - HOLD while the latched channel has Da_Vld=0: no output load; Ou_Vld drains when Ou_Rdy=1.
//  - Simultaneous events:
//    - Ou_Rdy=1 with a new grant in the same cycle: old beat leaves and new beat loads; no bubble.
//    - All GN valid with MODE=1: each channel is served once per GN transfers.
//  - Reset mid-packet returns to IDLE with P=0. Any beat in the output register is discarded.
//  - Da_Vld[i] must stay high, and channel-i data and Lst stable, until accepted. This block does not
//    check it; it is a producer obligation.
// STRUCTURE
//  - Shared package (mux_pkg): function clog2_min1(n); MODE_FIXED=0 and MODE_RR=1 constants.
//  - Sub-module rr_arb_pick
//    - Combinational; parameters GN and MODE.
//    - Inputs Req[GN] and Ptr[CW]; outputs one-hot Gnt[GN] and Idx[CW].
//    - Implemented by double-width rotate, priority pick, rotate back.
//  - Top level contains:
//    - AND-OR data select: per bit, the OR over i of (Da_In bit & Gnt[i]).
//    - Output register, pointer register and LOCK FSM.
// TESTING (GN=4, GW=8 unless stated)
//  1. Reset, then Da_Vld=0000 for 5 cycles -> Ou_Vld=0, Da_Ou=0x00, Ou_Gnt=0000, Da_Rdy=0000.
//  2. MODE=1, all Da_Vld=1111, Ou_Rdy=1, Da_In channel i = 0xA0+i for 8 cycles
//     -> Ou_Idx sequence 0,1,2,3,0,1,2,3; Da_Ou = 0xA0,0xA1,... one cycle after each Da_Rdy.
//  3. MODE=0, Da_Vld=1010 -> Ou_Idx stays 1. After Da_Vld[1]=0, Ou_Idx becomes 3.
//  4. Backpressure: Ou_Rdy=0 for 3 cycles with Ou_Vld=1 -> Da_Ou/Ou_Idx unchanged, Da_Rdy=0000.
//     After Ou_Rdy=1 -> next beat loads the following cycle with no lost or duplicate beat.
//  5. LOCK=1, ch2 sends a 3-beat packet (Lst on beat 3) while ch0 and ch3 are valid
//     -> Ou_Idx = 2,2,2, then 3 (P=3), then 0.
//  6. Rst asserted mid-packet (HOLD) with Ou_Vld=1 -> next cycle Ou_Vld=0, FSM IDLE, P=0.
//     Arbitration restarts at channel 0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants, types and helpers for the arbitrated data mux.
package mux_pkg;

  localparam int unsigned MODE_FIXED = 0;
  localparam int unsigned MODE_RR    = 1;

  typedef enum logic {StIdle, StHold} lock_st_e;

  // Index width for n channels, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned k = 0; k < 32; k++) begin
      if ((64'd1 << w) < 64'(n)) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational arbiter: rotate requests by the pointer, pick the lowest set bit, rotate back.
module rr_arb_pick import mux_pkg::*; #(
  parameter int unsigned GN   = 4,
  parameter int unsigned MODE = MODE_RR,
  localparam int unsigned CW  = clog2_min1(GN)
) (
  input  logic [GN-1:0] Req,
  input  logic [CW-1:0] Ptr,
  output logic [GN-1:0] Gnt,
  output logic [CW-1:0] Idx
);

  localparam logic [CW:0] GnW = (CW+1)'(GN);

  logic [CW-1:0]   p;
  logic [CW-1:0]   pos;
  logic            found;
  logic [2*GN-1:0] dbl;
  logic [2*GN-1:0] back;
  logic [GN-1:0]   rot;
  logic [GN-1:0]   pick;
  logic [CW:0]     sum;
  logic [CW:0]     wrapped;

  always_comb begin
    p     = (MODE == MODE_RR) ? Ptr : '0;
    dbl   = {Req, Req} >> p;
    rot   = dbl[GN-1:0];
    pick  = '0;
    pos   = '0;
    found = 1'b0;
    for (int i = 0; i < GN; i++) begin
      if (rot[i] && !found) begin
        pick[i] = 1'b1;
        pos     = CW'(i);
        found   = 1'b1;
      end
    end
    back    = {pick, pick} << p;
    Gnt     = back[2*GN-1:GN];
    sum     = {1'b0, pos} + {1'b0, p};
    wrapped = (sum >= GnW) ? (sum - GnW) : sum;
    Idx     = wrapped[CW-1:0];
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel arbitrated one-hot data mux with valid/ready handshake, registered output stage
// and optional packet lock that holds the grant until the last beat is accepted.
module rr_arb_mux import mux_pkg::*; #(
  parameter int unsigned GN   = 4,
  parameter int unsigned GW   = 8,
  parameter int unsigned MODE = MODE_RR,
  parameter int unsigned LOCK = 0,
  localparam int unsigned CW  = clog2_min1(GN)
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [GN*GW-1:0] Da_In,
  input  logic [GN-1:0]   Da_Vld,
  input  logic [GN-1:0]   Da_Lst,
  output logic [GN-1:0]   Da_Rdy,
  output logic [GW-1:0]   Da_Ou,
  output logic            Ou_Vld,
  output logic            Ou_Lst,
  output logic [GN-1:0]   Ou_Gnt,
  output logic [CW-1:0]   Ou_Idx,
  input  logic            Ou_Rdy
);

  localparam logic [CW-1:0] LastIdx = CW'(GN - 1);

  logic [GN-1:0] arb_gnt;
  logic [CW-1:0] arb_idx;
  logic [GN-1:0] gnt;
  logic [CW-1:0] idx;
  logic [GW-1:0] sel_data;
  logic          sel_lst;
  logic          ld;
  logic          xfer;
  logic          hold;

  logic [CW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] lock_idx_q;
  lock_st_e      st_q, st_d;

  logic [GW-1:0] data_q;
  logic          vld_q;
  logic          lst_q;
  logic [GN-1:0] gnt_q;
  logic [CW-1:0] idx_q;

  rr_arb_pick #(
    .GN   (GN),
    .MODE (MODE)
  ) u_pick (
    .Req (Da_Vld),
    .Ptr (ptr_q),
    .Gnt (arb_gnt),
    .Idx (arb_idx)
  );

  assign ld     = ~vld_q | Ou_Rdy;
  assign Da_Rdy = Rst ? '0 : (gnt & {GN{ld}});
  assign xfer   = |(Da_Vld & Da_Rdy);

  // A held grant points at the latched channel even when it has nothing to send.
  always_comb begin
    gnt = arb_gnt;
    idx = arb_idx;
    if (hold) begin
      gnt             = '0;
      gnt[lock_idx_q] = 1'b1;
      idx             = lock_idx_q;
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < GN; i++) begin
      sel_data = sel_data | (Da_In[GW*i +: GW] & {GW{gnt[i]}});
    end
    sel_lst = |(Da_Lst & gnt);
  end

  // Lock FSM: state register, next state, output decode.
  always_ff @(posedge Clk) begin
    if (Rst) st_q <= StIdle;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    if (LOCK != 0 && xfer) begin
      case (st_q)
        StIdle:  if (!sel_lst) st_d = StHold;
        StHold:  if (sel_lst)  st_d = StIdle;
        default: st_d = StIdle;
      endcase
    end
  end

  always_comb begin
    hold = (LOCK != 0) && (st_q == StHold);
  end

  // The pointer only moves once a packet (or a lone beat without lock) has fully gone.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer && (LOCK == 0 || sel_lst)) begin
      ptr_d = (idx == LastIdx) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      ptr_q      <= '0;
      lock_idx_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (xfer && st_q == StIdle) lock_idx_q <= idx;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      data_q <= '0;
      vld_q  <= 1'b0;
      lst_q  <= 1'b0;
      gnt_q  <= '0;
      idx_q  <= '0;
    end else if (ld) begin
      vld_q <= xfer;
      if (xfer) begin
        data_q <= sel_data;
        lst_q  <= sel_lst;
        gnt_q  <= gnt;
        idx_q  <= idx;
      end
    end
  end

  assign Da_Ou  = data_q;
  assign Ou_Vld = vld_q;
  assign Ou_Lst = lst_q;
  assign Ou_Gnt = gnt_q;
  assign Ou_Idx = idx_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: round-robin, fixed-priority and packet-lock instances
// driven from one shared stimulus.
module tb_rr_arb_mux;

  localparam int unsigned GN = 4;
  localparam int unsigned GW = 8;
  localparam int unsigned CW = 2;

  logic            clk;
  logic            rst;
  logic [GN*GW-1:0] din;
  logic [GN-1:0]   vld;
  logic [GN-1:0]   lst;
  logic            ordy;

  logic [GN-1:0] rr_rdy, fp_rdy, lk_rdy;
  logic [GW-1:0] rr_dou, fp_dou, lk_dou;
  logic          rr_ovld, fp_ovld, lk_ovld;
  logic          rr_olst, fp_olst, lk_olst;
  logic [GN-1:0] rr_ognt, fp_ognt, lk_ognt;
  logic [CW-1:0] rr_oidx, fp_oidx, lk_oidx;

  int total;
  int bad;

  rr_arb_mux #(.GN(GN), .GW(GW), .MODE(1), .LOCK(0)) u_rr (
    .Clk(clk), .Rst(rst), .Da_In(din), .Da_Vld(vld), .Da_Lst(lst), .Da_Rdy(rr_rdy),
    .Da_Ou(rr_dou), .Ou_Vld(rr_ovld), .Ou_Lst(rr_olst), .Ou_Gnt(rr_ognt), .Ou_Idx(rr_oidx),
    .Ou_Rdy(ordy)
  );

  rr_arb_mux #(.GN(GN), .GW(GW), .MODE(0), .LOCK(0)) u_fp (
    .Clk(clk), .Rst(rst), .Da_In(din), .Da_Vld(vld), .Da_Lst(lst), .Da_Rdy(fp_rdy),
    .Da_Ou(fp_dou), .Ou_Vld(fp_ovld), .Ou_Lst(fp_olst), .Ou_Gnt(fp_ognt), .Ou_Idx(fp_oidx),
    .Ou_Rdy(ordy)
  );

  rr_arb_mux #(.GN(GN), .GW(GW), .MODE(1), .LOCK(1)) u_lk (
    .Clk(clk), .Rst(rst), .Da_In(din), .Da_Vld(vld), .Da_Lst(lst), .Da_Rdy(lk_rdy),
    .Da_Ou(lk_dou), .Ou_Vld(lk_ovld), .Ou_Lst(lk_olst), .Ou_Gnt(lk_ognt), .Ou_Idx(lk_oidx),
    .Ou_Rdy(ordy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    ordy  = 1'b1;
    lst   = 4'b0000;
    din   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    vld   = 4'b1111;
    tick();
    tick();
    chk("rdy_in_reset", 32'(rr_rdy), 32'h0);

    // 1: idle after reset
    rst = 1'b0;
    vld = 4'b0000;
    for (int c = 0; c < 5; c++) tick();
    chk("idle_ovld", 32'(rr_ovld), 32'h0);
    chk("idle_dou", 32'(rr_dou), 32'h00);
    chk("idle_ognt", 32'(rr_ognt), 32'h0);
    chk("idle_rdy", 32'(rr_rdy), 32'h0);
    chk("idle_oidx", 32'(rr_oidx), 32'h0);

    // 2: round robin over all-valid
    vld = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("rr_rdy", 32'(rr_rdy), 32'(4'b0001 << (i % 4)));
      tick();
      chk("rr_oidx", 32'(rr_oidx), 32'(i % 4));
      chk("rr_dou", 32'(rr_dou), 32'(8'hA0 + (i % 4)));
      chk("rr_ognt", 32'(rr_ognt), 32'(4'b0001 << (i % 4)));
    end

    // 3: fixed priority
    vld = 4'b1010;
    tick();
    chk("fp_idx_a", 32'(fp_oidx), 32'd1);
    tick();
    chk("fp_idx_b", 32'(fp_oidx), 32'd1);
    chk("fp_dou", 32'(fp_dou), 32'hA1);
    vld = 4'b1000;
    tick();
    chk("fp_idx_c", 32'(fp_oidx), 32'd3);
    chk("fp_dou_c", 32'(fp_dou), 32'hA3);

    // 4: backpressure
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vld = 4'b1111;
    tick();
    chk("bp_first", 32'(rr_dou), 32'hA0);
    ordy = 1'b0;
    #1;
    chk("bp_rdy_stall", 32'(rr_rdy), 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_dou_hold", 32'(rr_dou), 32'hA0);
      chk("bp_idx_hold", 32'(rr_oidx), 32'd0);
      chk("bp_vld_hold", 32'(rr_ovld), 32'd1);
      chk("bp_rdy_hold", 32'(rr_rdy), 32'h0);
    end
    ordy = 1'b1;
    #1;
    chk("bp_rdy_release", 32'(rr_rdy), 32'b0010);
    tick();
    chk("bp_next_dou", 32'(rr_dou), 32'hA1);
    tick();
    chk("bp_after_dou", 32'(rr_dou), 32'hA2);

    // 5: packet lock, ch2 three beats while ch0 and ch3 wait
    rst = 1'b1;
    vld = 4'b0000;
    tick();
    rst = 1'b0;
    vld = 4'b0100;
    lst = 4'b0000;
    din = {8'h30, 8'h20, 8'h10, 8'h00};
    #1;
    chk("lk_rdy_b1", 32'(lk_rdy), 32'b0100);
    tick();
    chk("lk_idx_b1", 32'(lk_oidx), 32'd2);
    chk("lk_dou_b1", 32'(lk_dou), 32'h20);
    vld = 4'b1101;
    din = {8'h30, 8'h21, 8'h10, 8'h00};
    #1;
    chk("lk_rdy_b2", 32'(lk_rdy), 32'b0100);
    tick();
    chk("lk_idx_b2", 32'(lk_oidx), 32'd2);
    chk("lk_dou_b2", 32'(lk_dou), 32'h21);
    din = {8'h30, 8'h22, 8'h10, 8'h00};
    lst = 4'b0100;
    tick();
    chk("lk_idx_b3", 32'(lk_oidx), 32'd2);
    chk("lk_lst_b3", 32'(lk_olst), 32'd1);
    chk("lk_dou_b3", 32'(lk_dou), 32'h22);
    vld = 4'b1001;
    lst = 4'b1001;
    #1;
    chk("lk_rdy_ch3", 32'(lk_rdy), 32'b1000);
    tick();
    chk("lk_idx_ch3", 32'(lk_oidx), 32'd3);
    chk("lk_dou_ch3", 32'(lk_dou), 32'h30);
    vld = 4'b0001;
    tick();
    chk("lk_idx_ch0", 32'(lk_oidx), 32'd0);

    // Held channel goes idle: grant stays on it and the output drains.
    vld = 4'b0010;
    lst = 4'b0000;
    tick();
    chk("lk_idx_ch1", 32'(lk_oidx), 32'd1);
    vld = 4'b0001;
    #1;
    chk("lk_rdy_held", 32'(lk_rdy), 32'b0010);
    tick();
    chk("lk_drain", 32'(lk_ovld), 32'd0);
    vld = 4'b0010;
    tick();
    chk("lk_reload", 32'(lk_ovld), 32'd1);

    // 6: reset mid-packet
    rst = 1'b1;
    vld = 4'b1111;
    tick();
    chk("rst_ovld", 32'(lk_ovld), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_rdy", 32'(lk_rdy), 32'b0001);
    tick();
    chk("rst_idx", 32'(lk_oidx), 32'd0);
    chk("rst_vld", 32'(lk_ovld), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
